// File: rtl/obi_resp_pkg.sv
// obi_resp_pkg: shared types and constants for the OBI stall responder.
package obi_resp_pkg;

  // Grant sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } gnt_state_e;

  // One queued response: data to return and the cycle it was accepted
  typedef struct packed {
    logic [31:0] rdata;
    logic [15:0] ts;
  } resp_entry_t;

  // Read data returned for addresses outside the RAM
  localparam logic [31:0] OBI_RESP_ERR_DATA = 32'hDEAD_BEEF;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/obi_resp_fifo.sv
// obi_resp_fifo: in-order response queue holding up to DEPTH (1..8) entries.
module obi_resp_fifo
  import obi_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  resp_entry_t data_i,
  input  logic        pop_i,
  output resp_entry_t data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [3:0]  count_o
);

  localparam logic [2:0] LAST = 3'(DEPTH - 1);

  resp_entry_t slots [8];
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  count_q, count_d;
  logic        do_push, do_pop;

  assign full_o  = (count_q == 4'(DEPTH));
  assign empty_o = (count_q == 4'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = slots[rd_ptr_q];
  assign count_o = count_q;

  // Advance pointers with wrap at DEPTH and track occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? 3'd0 : wr_ptr_q + 3'd1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? 3'd0 : rd_ptr_q + 3'd1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset since occupancy guards every read
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      slots[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/obi_stall_responder.sv
// obi_stall_responder: OBI data-side memory model with configurable grant stalls,
// response latency and a cap on outstanding transactions.
// Optional feature: define OBI_RESP_RANDOM_STALL_EN to take each grant delay from an LFSR
// instead of GNT_DELAY.
module obi_stall_responder
  import obi_resp_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH  = 16,
  parameter int GNT_DELAY       = 0,
  parameter int RVALID_LATENCY  = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] stall_cnt_o
);

  localparam int WORD_AW   = RAM_ADDR_WIDTH - 2;
  localparam int NUM_WORDS = 2 ** WORD_AW;

  gnt_state_e         state_q, state_d;
  logic [2:0]         dly_cnt_q, dly_cnt_d;
  logic [15:0]        cycle_q, cycle_d;
  logic [31:0]        stall_q, stall_d;
  logic [2:0]         idle_delay, wait_delay;
  logic               gnt, accept, in_range, ram_we, pop, room;
  logic               fifo_full, fifo_empty;
  logic [3:0]         fifo_count;
  logic [WORD_AW-1:0] word_idx;
  logic [31:0]        ram_rdata;
  logic [15:0]        head_age;
  resp_entry_t        push_entry, head_entry;
  logic               unused_bits;
  logic [31:0]        ram_q [NUM_WORDS];

`ifdef OBI_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  dly_q, dly_d;

  // Free-running LFSR that supplies a fresh delay for each new request
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign idle_delay = lfsr_q[2:0];
  assign wait_delay = dly_q;
`else
  assign idle_delay = 3'(GNT_DELAY);
  assign wait_delay = 3'(GNT_DELAY);
`endif

  assign word_idx   = addr_i[RAM_ADDR_WIDTH-1:2];
  assign in_range   = ((addr_i >> RAM_ADDR_WIDTH) == 32'd0);
  assign room       = (fifo_count < 4'(MAX_OUTSTANDING));
  assign gnt_o      = gnt && rst_ni;
  assign accept     = req_i && gnt_o;
  assign ram_we     = accept && we_i && in_range;
  assign ram_rdata  = in_range ? ram_q[word_idx] : OBI_RESP_ERR_DATA;
  assign head_age   = cycle_q - head_entry.ts;
  assign pop        = rst_ni && !fifo_empty && (head_age >= 16'(RVALID_LATENCY));
  assign rvalid_o   = pop;
  assign rdata_o    = pop ? head_entry.rdata : 32'd0;
  assign stall_cnt_o = stall_q;
  assign unused_bits = ^{addr_i[1:0], fifo_full};

  always_comb begin
    push_entry.rdata = we_i ? 32'd0 : ram_rdata;
    push_entry.ts    = cycle_q;
  end

  // Grant sequencing: count out the stall delay, then grant once room exists
  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    gnt       = 1'b0;
`ifdef OBI_RESP_RANDOM_STALL_EN
    dly_d     = dly_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (idle_delay == 3'd0) begin
            gnt = room;
          end else begin
            state_d   = (idle_delay == 3'd1) ? ST_GRANT : ST_WAIT;
            dly_cnt_d = 3'd1;
`ifdef OBI_RESP_RANDOM_STALL_EN
            dly_d     = lfsr_q[2:0];
`endif
          end
        end
      end
      ST_WAIT: begin
        if (!req_i) begin
          state_d   = ST_IDLE;
          dly_cnt_d = 3'd0;
        end else begin
          dly_cnt_d = dly_cnt_q + 3'd1;
          if (dly_cnt_q + 3'd1 == wait_delay) begin
            state_d = ST_GRANT;
          end
        end
      end
      ST_GRANT: begin
        if (!req_i) begin
          state_d   = ST_IDLE;
          dly_cnt_d = 3'd0;
        end else begin
          gnt = room;
          if (room) begin
            state_d   = ST_IDLE;
            dly_cnt_d = 3'd0;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        dly_cnt_d = 3'd0;
      end
    endcase
  end

  // Cycle timestamp and saturating stall counter
  always_comb begin
    cycle_d = cycle_q + 16'd1;
    stall_d = stall_q;
    if (req_i && !gnt_o && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Control state registers; RAM is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      dly_cnt_q <= 3'd0;
      cycle_q   <= 16'd0;
      stall_q   <= 32'd0;
`ifdef OBI_RESP_RANDOM_STALL_EN
      lfsr_q    <= LFSR_SEED;
      dly_q     <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      cycle_q   <= cycle_d;
      stall_q   <= stall_d;
`ifdef OBI_RESP_RANDOM_STALL_EN
      lfsr_q    <= lfsr_d;
      dly_q     <= dly_d;
`endif
    end
  end

  // Byte-masked RAM write at the acceptance edge
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          ram_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  obi_resp_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (accept),
    .data_i (push_entry),
    .pop_i  (pop),
    .data_o (head_entry),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_obi_stall_responder.sv
// tb_obi_stall_responder: scoreboard bench for obi_stall_responder.
// Instance A uses default parameters, B a five-cycle response latency,
// C a three-cycle grant delay.
module tb_obi_stall_responder;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk;
   logic        rstA, rstB;
   logic        req, sel, reqA, reqB, reqC;
   logic        we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;

   logic        gntA, rvalidA, gntB, rvalidB, gntC, rvalidC;
   logic [31:0] rdataA, stallA, rdataB, stallB, rdataC, stallC;

   exp_t expQA[$];
   exp_t expQB[$];
   int   tbCycle = 0;
   int   testsRun = 0;
   int   testsFailed = 0;

   assign reqA = req & ~sel;
   assign reqB = req & sel;

   obi_stall_responder u_dutA (
      .clk_i(clk), .rst_ni(rstA), .req_i(reqA), .addr_i(addr), .we_i(we), .be_i(be),
      .wdata_i(wdata), .gnt_o(gntA), .rvalid_o(rvalidA), .rdata_o(rdataA), .stall_cnt_o(stallA)
   );

   obi_stall_responder #(.RVALID_LATENCY(5), .MAX_OUTSTANDING(2)) u_dutB (
      .clk_i(clk), .rst_ni(rstB), .req_i(reqB), .addr_i(addr), .we_i(we), .be_i(be),
      .wdata_i(wdata), .gnt_o(gntB), .rvalid_o(rvalidB), .rdata_o(rdataB), .stall_cnt_o(stallB)
   );

   obi_stall_responder #(.GNT_DELAY(3)) u_dutC (
      .clk_i(clk), .rst_ni(rstA), .req_i(reqC), .addr_i(addr), .we_i(we), .be_i(be),
      .wdata_i(wdata), .gnt_o(gntC), .rvalid_o(rvalidC), .rdata_o(rdataC), .stall_cnt_o(stallC)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single point of comparison: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Issue one transaction to A or B, wait for its grant, and queue the expected response
   task automatic applyStimulus(input bit toB, input logic w, input logic [31:0] a,
                                input logic [3:0] b, input logic [31:0] d,
                                input logic [31:0] expData, output int grantCycle);
      int   waitCycles;
      exp_t e;
      waitCycles = 0;
      sel = toB; req = 1'b1; we = w; addr = a; be = b; wdata = d;
      #1;
      while (!(toB ? gntB : gntA) && waitCycles < 50) begin
         @(negedge clk);
         #1;
         waitCycles++;
      end
      grantCycle = tbCycle;
      if (!(toB ? gntB : gntA)) begin
         checkOutput("grant_timeout", 32'd0, 32'd1);
      end else begin
         e.data = w ? 32'd0 : expData;
         e.due  = tbCycle + (toB ? 5 : 1);
         if (toB) expQB.push_back(e);
         else     expQA.push_back(e);
      end
      @(negedge clk);
   endtask

   // Response monitor: every rvalid must match the oldest expected entry, at its due cycle
   always @(posedge clk) begin
      exp_t e;
      tbCycle++;
      #1;
      if (rvalidA) begin
         if (expQA.size() == 0) checkOutput("A_unexpected_rvalid", 32'd1, 32'd0);
         else begin
            e = expQA.pop_front();
            checkOutput("A_rdata", rdataA, e.data);
            checkOutput("A_latency", tbCycle, e.due);
         end
      end else begin
         checkOutput("A_rdata_idle", rdataA, 32'd0);
      end
      if (rvalidB) begin
         if (expQB.size() == 0) checkOutput("B_unexpected_rvalid", 32'd1, 32'd0);
         else begin
            e = expQB.pop_front();
            checkOutput("B_rdata", rdataB, e.data);
            checkOutput("B_latency", tbCycle, e.due);
         end
      end else begin
         checkOutput("B_rdata_idle", rdataB, 32'd0);
      end
   end

   // Main stimulus sequence
   initial begin
      int          g, g1, g2, g3;
      logic [31:0] model [8];
      logic [31:0] dat;
      logic [3:0]  bemask;

      rstA = 1'b0; rstB = 1'b0; req = 1'b0; sel = 1'b0; reqC = 1'b0;
      we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;

      // Outputs held at zero while reset is asserted, even with a request pending
      repeat (3) @(negedge clk);
      req = 1'b1; reqC = 1'b1; we = 1'b0; addr = 32'h100; be = 4'hF;
      #1;
      checkOutput("rst_gntA", gntA, 32'd0);
      checkOutput("rst_rvalidA", rvalidA, 32'd0);
      checkOutput("rst_rdataA", rdataA, 32'd0);
      checkOutput("rst_gntC", gntC, 32'd0);
      @(negedge clk);
      #1;
      checkOutput("rst_stallA", stallA, 32'd0);
      req = 1'b0; reqC = 1'b0;
      @(negedge clk);
      rstA = 1'b1; rstB = 1'b1;
      @(negedge clk);

      // Full write then read back; partial write merge; out-of-range accesses
      applyStimulus(0, 1, 32'h100, 4'hF, 32'h11223344, 32'd0, g);
      applyStimulus(0, 0, 32'h100, 4'hF, 32'd0, 32'h11223344, g);
      applyStimulus(0, 1, 32'h100, 4'b0101, 32'hAABBCCDD, 32'd0, g);
      applyStimulus(0, 0, 32'h100, 4'hF, 32'd0, 32'h11BB33DD, g);
      applyStimulus(0, 0, 32'h0001_0000, 4'hF, 32'd0, 32'hDEADBEEF, g);
      applyStimulus(0, 1, 32'h0001_0100, 4'hF, 32'hFFFF_FFFF, 32'd0, g);
      applyStimulus(0, 0, 32'h100, 4'hF, 32'd0, 32'h11BB33DD, g);
      req = 1'b0;
      repeat (3) @(negedge clk);

      // Random byte-masked writes against a reference model, then back-to-back reads
      for (int i = 0; i < 8; i++) begin
         model[i] = $urandom;
         applyStimulus(0, 1, 32'h200 + 32'(4 * i), 4'hF, model[i], 32'd0, g);
      end
      for (int i = 0; i < 8; i++) begin
         bemask = 4'($urandom_range(0, 15));
         dat = $urandom;
         for (int bi = 0; bi < 4; bi++) begin
            if (bemask[bi]) model[i][8*bi +: 8] = dat[8*bi +: 8];
         end
         applyStimulus(0, 1, 32'h200 + 32'(4 * i), bemask, dat, 32'd0, g);
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 32'h200 + 32'(4 * i), 4'hF, 32'd0, model[i], g);
      end
      req = 1'b0;
      repeat (3) @(negedge clk);

      // B: outstanding limit of 2 with latency 5 withholds the third grant
      applyStimulus(1, 1, 32'h10, 4'hF, 32'hCAFE0001, 32'd0, g);
      applyStimulus(1, 1, 32'h14, 4'hF, 32'hCAFE0002, 32'd0, g);
      applyStimulus(1, 1, 32'h18, 4'hF, 32'hCAFE0003, 32'd0, g);
      req = 1'b0;
      repeat (10) @(negedge clk);
      applyStimulus(1, 0, 32'h10, 4'hF, 32'd0, 32'hCAFE0001, g1);
      applyStimulus(1, 0, 32'h14, 4'hF, 32'd0, 32'hCAFE0002, g2);
      applyStimulus(1, 0, 32'h18, 4'hF, 32'd0, 32'hCAFE0003, g3);
      req = 1'b0;
      checkOutput("B_back_to_back_gnt", 32'(g2), 32'(g1 + 1));
      checkOutput("B_third_gnt_withheld", 32'(g3), 32'(g1 + 6));
      #1;
      checkOutput("B_stall_cnt", stallB, 32'd8);
      repeat (10) @(negedge clk);

      // B: reset with two responses pending discards them
      applyStimulus(1, 0, 32'h10, 4'hF, 32'd0, 32'hCAFE0001, g);
      applyStimulus(1, 0, 32'h14, 4'hF, 32'd0, 32'hCAFE0002, g);
      rstB = 1'b0;
      expQB.delete();
      #1;
      checkOutput("B_rst_gnt", gntB, 32'd0);
      checkOutput("B_rst_rvalid", rvalidB, 32'd0);
      @(negedge clk);
      @(negedge clk);
      req = 1'b0; rstB = 1'b1;
      @(posedge clk);
      #2;
      checkOutput("B_post_rst_rvalid", rvalidB, 32'd0);
      checkOutput("B_post_rst_rdata", rdataB, 32'd0);
      checkOutput("B_post_rst_stall", stallB, 32'd0);
      repeat (10) @(negedge clk);

      // C: grant delay of 3 with req held, then an abandoned request restarts the count
      sel = 1'b0; we = 1'b1; addr = 32'h40; be = 4'hF; wdata = 32'h5A5A5A5A;
      reqC = 1'b1;
      for (int n = 0; n < 4; n++) begin
         #1;
         checkOutput("C_delay_gnt", {31'd0, gntC}, 32'(n == 3));
         @(negedge clk);
      end
      reqC = 1'b0;
      #1;
      checkOutput("C_stall_cnt", stallC, 32'd3);
      @(negedge clk);
      reqC = 1'b1;
      for (int n = 0; n < 2; n++) begin
         #1;
         checkOutput("C_abandon_gnt", {31'd0, gntC}, 32'd0);
         @(negedge clk);
      end
      reqC = 1'b0;
      @(negedge clk);
      reqC = 1'b1;
      for (int n = 0; n < 4; n++) begin
         #1;
         checkOutput("C_restart_gnt", {31'd0, gntC}, 32'(n == 3));
         @(negedge clk);
      end
      reqC = 1'b0;
      #1;
      checkOutput("C_stall_cnt_total", stallC, 32'd8);

      // Drain and final checks
      for (int i = 0; i < 50 && (expQA.size() != 0 || expQB.size() != 0); i++) @(negedge clk);
      checkOutput("A_drain", 32'(expQA.size()), 32'd0);
      checkOutput("B_drain", 32'(expQB.size()), 32'd0);
      checkOutput("A_stall_cnt", stallA, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/obi_stall_responder.md
OBI_STALL_RESPONDER -- requirements
Module: obi_stall_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 16: byte-address width of internal RAM; 2**(RAM_ADDR_WIDTH-2) words.
REQ-002 SHALL have parameter GNT_DELAY, default 0: cycles req_i is held high before gnt_o asserts; range 0..7.
REQ-003 SHALL have parameter RVALID_LATENCY, default 1: minimum cycles from acceptance to rvalid_o; range 1..15.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2: maximum number of accepted transactions without a response; range 1..8.
REQ-005 SHALL have port clk_i, input, 1: the only clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: synchronous, active-low reset.
REQ-007 SHALL have ports req_i (in, 1), addr_i (in, 32), we_i (in, 1), be_i (in, 4) and wdata_i (in, 32): the OBI request from the core's data initiator.
REQ-008 SHALL have ports gnt_o (out, 1), rvalid_o (out, 1) and rdata_o (out, 32): the OBI grant and response.
REQ-009 SHALL have port stall_cnt_o, out, 32: count of cycles with req_i=1 and gnt_o=0.

Function
REQ-010 Transaction acceptance SHALL occur on any cycle with req_i && gnt_o.
REQ-011 The grant FSM SHALL have three states:
- IDLE -> WAIT on req_i when the delay is nonzero.
- WAIT counts the delay; WAIT -> GRANT when the count reaches the delay.
- GRANT -> IDLE on acceptance.
- Any state -> IDLE when req_i drops without a grant, with the counter cleared.
REQ-012 With delay 0, gnt_o SHALL be combinational: gnt_o = req_i && (count < MAX_OUTSTANDING), in the same cycle.
REQ-013 gnt_o SHALL be 0 whenever the outstanding count equals MAX_OUTSTANDING; there is no same-cycle pop-to-grant pass-through.
REQ-014 An accepted write SHALL update the RAM word addr_i[RAM_ADDR_WIDTH-1:2], enabling only the bytes selected by be_i, at the acceptance edge.
REQ-015 An accepted read SHALL capture the RAM word at acceptance, reflecting all earlier accepted writes, into the response FIFO.
REQ-016 If addr_i[31:RAM_ADDR_WIDTH] != 0: writes SHALL be discarded, and reads SHALL return 32'hDEAD_BEEF.
REQ-017 The FIFO entry SHALL store the read data (0 for writes) and the accept timestamp from a free-running 16-bit cycle counter.
REQ-018 rvalid_o SHALL assert for exactly one cycle per transaction, in acceptance order, when (cycle - head timestamp) mod 2**16 >= RVALID_LATENCY; rdata_o SHALL be valid only in that cycle.
REQ-019 At most one response SHALL be issued per cycle; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-020 rdata_o SHALL be 0 when rvalid_o = 0.
REQ-021 stall_cnt_o SHALL increment on each req_i && !gnt_o cycle and saturate at 32'hFFFF_FFFF.

Reset
REQ-022 On rst_ni = 0 at a clock edge, the following SHALL be cleared: FSM to IDLE, delay counter, cycle counter, FIFO (emptied), stall_cnt_o.
REQ-023 During reset, gnt_o, rvalid_o and rdata_o SHALL be 0.
REQ-024 RAM contents SHALL NOT be reset.
REQ-025 Responses pending when reset is applied mid-operation SHALL be discarded; no rvalid_o SHALL follow reset for a pre-reset request.

Configuration
REQ-026 Macro OBI_RESP_RANDOM_STALL_EN, when defined, SHALL:
- instantiate a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advancing every cycle;
- load the per-transaction grant delay from lfsr[2:0] on IDLE->WAIT entry, replacing GNT_DELAY.
REQ-027 When OBI_RESP_RANDOM_STALL_EN is undefined, the delay SHALL be GNT_DELAY and no LFSR logic SHALL exist.

Structure
REQ-028 Package obi_resp_pkg SHALL hold:
- the FSM state enum;
- the FIFO entry struct (rdata, timestamp);
- the constant 32'hDEAD_BEEF;
- the LFSR seed and taps.
REQ-029 The response queue SHALL be sub-module obi_resp_fifo (depth MAX_OUTSTANDING, push/pop/full/empty/count).

Verification
REQ-030 Write 0x11223344 to 0x100 with be=4'b1111, then read 0x100 -> rdata_o = 0x11223344 after 1 cycle (RVALID_LATENCY=1).
REQ-031 Write 0xAABBCCDD with be=4'b0101 over 0x11223344, then read -> rdata_o = 0x11BB33DD.
REQ-032 GNT_DELAY=3, req_i held -> gnt_o high on the 4th req cycle; stall_cnt_o = 3.
REQ-033 MAX_OUTSTANDING=2, RVALID_LATENCY=5, back-to-back reads -> third gnt_o withheld until the first rvalid_o; responses in order.
REQ-034 Read of 0x0001_0000 with RAM_ADDR_WIDTH=16 -> rdata_o = 0xDEADBEEF; a write there leaves the RAM unchanged.
REQ-035 Reset asserted with 2 responses pending -> no rvalid_o afterward; outputs are 0 at the first post-reset edge.
